// File: rtl/pipe_hazard_unit_pkg.sv
// rtl/pipe_hazard_unit_pkg.sv - shared record types and helpers for the pipeline hazard unit
package pipe_hazard_unit_pkg;

    // Upper bound on register address width; narrower addresses are zero-extended into rd
    localparam int MAX_REG_AW = 8;

    typedef enum logic [1:0] {
        CLS_ALU = 2'd0,
        CLS_LW  = 2'd1,
        CLS_MUL = 2'd2
    } cls_e;

    typedef struct packed {
        logic                  val;
        logic                  wen;
        logic [MAX_REG_AW-1:0] rd;
        cls_e                  cls;
    } stage_rec_t;

    function automatic int sel_width(input int nstages);
        return $clog2(nstages + 1);
    endfunction

    // A result can be forwarded from stage k once its producing unit has finished:
    // ALU in X, the multiplier once it has left X, a load once past the memory stage
    function automatic logic is_ready(input cls_e cls, input int k, input int mem_stage);
        logic r;
        case (cls)
            CLS_ALU: r = 1'b1;
            CLS_MUL: r = (k >= 2);
            CLS_LW:  r = (k > mem_stage);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_hazard_match.sv
// rtl/pipe_hazard_match.sv - youngest in-flight writer lookup for one source operand
// recs: stage records 1..NSTAGES; src_en/src: operand read enable and address
// hit: a writer of src is in flight; ready: its result is forwardable; k: its stage
module pipe_hazard_match
    import pipe_hazard_unit_pkg::*;
#(
    parameter int NSTAGES   = 3,
    parameter int MEM_STAGE = 2,
    parameter int REG_AW    = 5,
    parameter int SEL_W     = sel_width(NSTAGES)
) (
    input  stage_rec_t [NSTAGES:1] recs,
    input  logic                   src_en,
    input  logic [REG_AW-1:0]      src,
    output logic                   hit,
    output logic                   ready,
    output logic [SEL_W-1:0]       k
);

    // Scan oldest to youngest so the lowest-numbered (youngest) match is the one kept
    always_comb begin
        hit   = 1'b0;
        ready = 1'b0;
        k     = '0;
        for (int s = NSTAGES; s >= 1; s--) begin
            if (src_en && (src != '0) && recs[s].val && recs[s].wen &&
                (recs[s].rd == MAX_REG_AW'(src))) begin
                hit   = 1'b1;
                ready = is_ready(recs[s].cls, s, MEM_STAGE);
                k     = SEL_W'(s);
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_unit.sv
// rtl/pipe_hazard_unit.sv - stall/bypass/writeback control for TinyRV1; forwarding enabled by PIPE_HAZARD_BYPASS_EN
module pipe_hazard_unit
    import pipe_hazard_unit_pkg::*;
#(
    parameter int NSTAGES   = 3,
    parameter int MEM_STAGE = 2,
    parameter int MUL_LAT   = 4,
    parameter int REG_AW    = 5
) (
    input  logic                           clk,
    input  logic                           rst,            // synchronous, active high
    input  logic                           val_D,          // decode instruction
    input  logic                           squash_D,
    input  logic                           rs1_en_D,
    input  logic                           rs2_en_D,
    input  logic [REG_AW-1:0]              rs1_D,
    input  logic [REG_AW-1:0]              rs2_D,
    input  logic                           rf_wen_D,
    input  logic [REG_AW-1:0]              rd_D,
    input  logic                           is_lw_D,
    input  logic                           is_mul_D,
    input  logic                           mem_wait_M,     // dmem response outstanding
    output logic                           stall_F,        // stall controls
    output logic                           stall_D,
    output logic                           stall_X,
    output logic                           stall_M,
    output logic [$clog2(NSTAGES+1)-1:0]   op1_byp_sel_D,  // 0 = RF, k = stage k
    output logic [$clog2(NSTAGES+1)-1:0]   op2_byp_sel_D,
    output logic                           rf_wen_W,       // writeback
    output logic [REG_AW-1:0]              rf_waddr_W
);

    localparam int         SEL_W    = sel_width(NSTAGES);
    localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

    stage_rec_t [NSTAGES:1] rec_q, rec_d;
    logic [3:0]             mul_cnt_q, mul_cnt_d;

    logic             hit1, hit2, rdy1, rdy2;
    logic [SEL_W-1:0] k1, k2;
    logic             haz1, haz2;
    logic [SEL_W-1:0] sel1, sel2;
    logic             s1_mul, hold_x, hazard;
    stage_rec_t       issue_rec;

    pipe_hazard_match #(
        .NSTAGES(NSTAGES), .MEM_STAGE(MEM_STAGE), .REG_AW(REG_AW), .SEL_W(SEL_W)
    ) u_match_rs1 (
        .recs(rec_q), .src_en(rs1_en_D), .src(rs1_D), .hit(hit1), .ready(rdy1), .k(k1)
    );

    pipe_hazard_match #(
        .NSTAGES(NSTAGES), .MEM_STAGE(MEM_STAGE), .REG_AW(REG_AW), .SEL_W(SEL_W)
    ) u_match_rs2 (
        .recs(rec_q), .src_en(rs2_en_D), .src(rs2_D), .hit(hit2), .ready(rdy2), .k(k2)
    );

`ifdef PIPE_HAZARD_BYPASS_EN
    always_comb begin
        haz1 = hit1 & ~rdy1;
        haz2 = hit2 & ~rdy2;
        sel1 = (hit1 & rdy1) ? k1 : '0;
        sel2 = (hit2 & rdy2) ? k2 : '0;
    end
`else
    // Without forwarding the operand must come from the register file, so any
    // in-flight writer blocks decode until it has retired
    logic unused_match;
    assign unused_match = ^{rdy1, rdy2, k1, k2};

    always_comb begin
        haz1 = hit1;
        haz2 = hit2;
        sel1 = '0;
        sel2 = '0;
    end
`endif

    always_comb begin
        s1_mul  = rec_q[1].val && (rec_q[1].cls == CLS_MUL);
        hold_x  = s1_mul && (mul_cnt_q != MUL_LAST);
        hazard  = haz1 | haz2;

        stall_D = val_D & (hazard | hold_x | mem_wait_M);
        stall_F = stall_D;
        stall_X = hold_x | mem_wait_M;
        stall_M = mem_wait_M;

        op1_byp_sel_D = sel1;
        op2_byp_sel_D = sel2;

        rf_wen_W   = rec_q[NSTAGES].val & rec_q[NSTAGES].wen;
        rf_waddr_W = rec_q[NSTAGES].rd[REG_AW-1:0];
    end

    always_comb begin
        issue_rec     = '0;
        issue_rec.val = val_D & ~squash_D & ~stall_D;
        issue_rec.wen = rf_wen_D;
        issue_rec.rd  = MAX_REG_AW'(rd_D);
        issue_rec.cls = is_lw_D ? CLS_LW : (is_mul_D ? CLS_MUL : CLS_ALU);
    end

    // The frozen region (1..MEM_STAGE on a memory wait, 1 on a multiply hold)
    // keeps its records; the stage right above it receives a bubble
    always_comb begin
        rec_d = rec_q;
        if (mem_wait_M) begin
            for (int s = NSTAGES; s > MEM_STAGE + 1; s--) begin
                rec_d[s] = rec_q[s-1];
            end
            rec_d[MEM_STAGE+1] = '0;
        end else if (hold_x) begin
            for (int s = NSTAGES; s > 2; s--) begin
                rec_d[s] = rec_q[s-1];
            end
            rec_d[2] = '0;
        end else begin
            for (int s = NSTAGES; s > 1; s--) begin
                rec_d[s] = rec_q[s-1];
            end
            rec_d[1] = issue_rec;
        end
    end

    // Counter runs while a MUL sits in X, including memory freezes, and restarts
    // whenever stage 1 advances so a following MUL starts from zero
    always_comb begin
        mul_cnt_d = '0;
        if (s1_mul && (hold_x || mem_wait_M)) begin
            mul_cnt_d = (mul_cnt_q == MUL_LAST) ? mul_cnt_q : mul_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rec_q     <= '0;
            mul_cnt_q <= '0;
        end else begin
            rec_q     <= rec_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// tb/tb_pipe_hazard_unit.sv - randomized and directed bench for pipe_hazard_unit
module tb_pipe_hazard_unit;

    localparam int NS = 3;
    localparam int MS = 2;
    localparam int ML = 4;
    localparam int AW = 5;
    localparam int SW = $clog2(NS + 1);
`ifdef PIPE_HAZARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk, rst;
    logic val_D, squash_D, rs1_en_D, rs2_en_D, rf_wen_D, is_lw_D, is_mul_D, mem_wait_M;
    logic [AW-1:0] rs1_D, rs2_D, rd_D;
    logic stall_F, stall_D, stall_X, stall_M, rf_wen_W;
    logic [SW-1:0] op1_byp_sel_D, op2_byp_sel_D;
    logic [AW-1:0] rf_waddr_W;

    int tests_run = 0;
    int tests_failed = 0;

    pipe_hazard_unit #(.NSTAGES(NS), .MEM_STAGE(MS), .MUL_LAT(ML), .REG_AW(AW)) dut (
        .clk(clk), .rst(rst), .val_D(val_D), .squash_D(squash_D),
        .rs1_en_D(rs1_en_D), .rs2_en_D(rs2_en_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
        .rf_wen_D(rf_wen_D), .rd_D(rd_D), .is_lw_D(is_lw_D), .is_mul_D(is_mul_D),
        .mem_wait_M(mem_wait_M), .stall_F(stall_F), .stall_D(stall_D),
        .stall_X(stall_X), .stall_M(stall_M), .op1_byp_sel_D(op1_byp_sel_D),
        .op2_byp_sel_D(op2_byp_sel_D), .rf_wen_W(rf_wen_W), .rf_waddr_W(rf_waddr_W)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: one slot per stage, cls 0=ALU 1=LW 2=MUL
    bit m_val[1:8], n_val[1:8];
    bit m_wen[1:8], n_wen[1:8];
    int m_rd[1:8],  n_rd[1:8];
    int m_cls[1:8], n_cls[1:8];
    int m_cnt = 0, n_cnt = 0;
    bit model_live = 1'b0;

    function automatic void src_eval(input bit en, input int a, output bit haz, output int sel);
        bit rdy;
        haz = 1'b0;
        sel = 0;
        if (en && a != 0) begin
            for (int k = 1; k <= NS; k++) begin
                if (m_val[k] && m_wen[k] && m_rd[k] == a) begin
                    rdy = (m_cls[k] == 0) || (m_cls[k] == 2 && k >= 2) || (m_cls[k] == 1 && k > MS);
                    if (BYP && rdy) sel = k;
                    else haz = 1'b1;
                    break;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        bit h1, h2, holdx, e_sd, e_wen;
        int s1, s2, f;
        src_eval(rs1_en_D, int'(rs1_D), h1, s1);
        src_eval(rs2_en_D, int'(rs2_D), h2, s2);
        holdx = m_val[1] && m_cls[1] == 2 && m_cnt < ML - 1;
        e_sd  = val_D && (h1 || h2 || holdx || mem_wait_M);
        e_wen = m_val[NS] && m_wen[NS];
        if (model_live) begin
            chk("model_stall_F", stall_F, e_sd);
            chk("model_stall_D", stall_D, e_sd);
            chk("model_stall_X", stall_X, holdx || mem_wait_M);
            chk("model_stall_M", stall_M, mem_wait_M);
            chk("model_sel1", op1_byp_sel_D, s1);
            chk("model_sel2", op2_byp_sel_D, s2);
            chk("model_rf_wen_W", rf_wen_W, e_wen);
            if (e_wen) chk("model_rf_waddr_W", rf_waddr_W, m_rd[NS]);
        end
        // stages 1..f stay frozen, stage f+1 gets a bubble (or the issued instr when f=0)
        f = mem_wait_M ? MS : (holdx ? 1 : 0);
        n_val = m_val; n_wen = m_wen; n_rd = m_rd; n_cls = m_cls;
        for (int k = NS; k >= 1; k--) begin
            if (k == f + 1) begin
                if (f == 0) begin
                    n_val[1] = val_D && !squash_D && !e_sd;
                    n_wen[1] = rf_wen_D;
                    n_rd[1]  = int'(rd_D);
                    n_cls[1] = is_lw_D ? 1 : (is_mul_D ? 2 : 0);
                end else begin
                    n_val[k] = 1'b0; n_wen[k] = 1'b0; n_rd[k] = 0; n_cls[k] = 0;
                end
            end else if (k > f + 1) begin
                n_val[k] = m_val[k-1]; n_wen[k] = m_wen[k-1];
                n_rd[k]  = m_rd[k-1];  n_cls[k] = m_cls[k-1];
            end
        end
        if (m_val[1] && m_cls[1] == 2 && f != 0) n_cnt = (m_cnt + 1 > ML - 1) ? ML - 1 : m_cnt + 1;
        else n_cnt = 0;
        if (rst) begin
            for (int k = 1; k <= 8; k++) begin
                n_val[k] = 1'b0; n_wen[k] = 1'b0; n_rd[k] = 0; n_cls[k] = 0;
            end
            n_cnt = 0;
        end
    end

    always @(posedge clk) begin
        m_val = n_val; m_wen = n_wen; m_rd = n_rd; m_cls = n_cls; m_cnt = n_cnt;
        if (rst) model_live = 1'b1;
    end

    // ---------------- stimulus
    task automatic idle();
        val_D = 0; squash_D = 0; rs1_en_D = 0; rs2_en_D = 0; rs1_D = '0; rs2_D = '0;
        rf_wen_D = 0; rd_D = '0; is_lw_D = 0; is_mul_D = 0; mem_wait_M = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            idle();
        end
    endtask

    task automatic instr(input int rd, input bit wen, input bit e1, input int r1,
                         input bit e2, input int r2, input bit lw, input bit mul);
        idle();
        val_D = 1; rd_D = AW'(rd); rf_wen_D = wen;
        rs1_en_D = e1; rs1_D = AW'(r1); rs2_en_D = e2; rs2_D = AW'(r2);
        is_lw_D = lw; is_mul_D = mul;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        @(negedge clk);
        chk("reset_stall_D", stall_D, 0);
        chk("reset_stall_X", stall_X, 0);
        chk("reset_stall_M", stall_M, 0);
        chk("reset_sel1", op1_byp_sel_D, 0);
        chk("reset_sel2", op2_byp_sel_D, 0);
        chk("reset_rf_wen_W", rf_wen_W, 0);
        chk("reset_rf_waddr_W", rf_waddr_W, 0);
        cyc();
        rst = 1'b0;

        // ALU producer then back-to-back consumer
        cyc(); instr(3, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk); chk("alu_issue_stall_D", stall_D, 0);
        cyc(); instr(8, 1, 1, 3, 0, 0, 0, 0);
        @(negedge clk);
        chk("alu_use_sel1", op1_byp_sel_D, BYP ? 1 : 0);
        chk("alu_use_stall_D", stall_D, BYP ? 0 : 1);
        drain(4);

        // load-use
        cyc(); instr(5, 1, 0, 0, 0, 0, 1, 0);
        cyc(); instr(6, 1, 1, 5, 1, 5, 0, 0);
        @(negedge clk); chk("lw_use_stall_c1", stall_D, 1);
        cyc(); @(negedge clk); chk("lw_use_stall_c2", stall_D, 1);
        cyc(); @(negedge clk);
        chk("lw_use_stall_c3", stall_D, BYP ? 0 : 1);
        chk("lw_use_sel1", op1_byp_sel_D, BYP ? 3 : 0);
        chk("lw_use_sel2", op2_byp_sel_D, BYP ? 3 : 0);
        drain(4);

        // mul-use
        cyc(); instr(7, 1, 0, 0, 0, 0, 0, 1);
        cyc(); instr(9, 1, 1, 7, 0, 0, 0, 0);
        @(negedge clk); chk("mul_stall_X_c1", stall_X, 1); chk("mul_stall_D_c1", stall_D, 1);
        cyc(); @(negedge clk); chk("mul_stall_X_c2", stall_X, 1);
        cyc(); @(negedge clk); chk("mul_stall_X_c3", stall_X, 1);
        cyc(); @(negedge clk); chk("mul_stall_X_c4", stall_X, 0); chk("mul_stall_D_c4", stall_D, 1);
        cyc(); @(negedge clk);
        chk("mul_use_stall_D", stall_D, BYP ? 0 : 1);
        chk("mul_use_sel1", op1_byp_sel_D, BYP ? 2 : 0);
        drain(4);

        // memory wait with ADD x4 in W
        cyc(); instr(4, 1, 0, 0, 0, 0, 0, 0);
        cyc(); idle();
        cyc(); idle();
        cyc(); idle(); mem_wait_M = 1;
        @(negedge clk);
        chk("memw_rf_wen_c1", rf_wen_W, 1); chk("memw_waddr_c1", rf_waddr_W, 4);
        chk("memw_stall_M_c1", stall_M, 1); chk("memw_stall_X_c1", stall_X, 1);
        cyc(); @(negedge clk); chk("memw_rf_wen_c2", rf_wen_W, 0); chk("memw_stall_M_c2", stall_M, 1);
        cyc(); @(negedge clk); chk("memw_rf_wen_c3", rf_wen_W, 0); chk("memw_stall_M_c3", stall_M, 1);
        cyc(); idle(); @(negedge clk); chk("memw_stall_M_off", stall_M, 0);

        // squash behaviour and x0 writers
        cyc(); instr(10, 1, 0, 0, 0, 0, 0, 0); squash_D = 1;
        @(negedge clk); chk("squash_stall_D", stall_D, 0);
        cyc(); instr(12, 1, 1, 10, 0, 0, 0, 0);
        @(negedge clk); chk("squash_sel1", op1_byp_sel_D, 0); chk("squash_use_stall_D", stall_D, 0);
        cyc(); instr(5, 1, 0, 0, 0, 0, 1, 0);
        cyc(); instr(11, 1, 1, 5, 0, 0, 0, 0); squash_D = 1;
        @(negedge clk); chk("squash_and_stall_D", stall_D, 1);
        cyc(); instr(13, 1, 1, 11, 0, 0, 0, 0);
        @(negedge clk); chk("squash_stall_sel1", op1_byp_sel_D, 0); chk("squash_stall_use_D", stall_D, 0);
        cyc(); instr(0, 1, 0, 0, 0, 0, 0, 0);
        cyc(); instr(14, 1, 1, 0, 1, 0, 0, 0);
        @(negedge clk); chk("x0_sel1", op1_byp_sel_D, 0); chk("x0_stall_D", stall_D, 0);
        drain(4);

        // reset with a load in stage 2
        cyc(); instr(5, 1, 0, 0, 0, 0, 1, 0);
        cyc(); idle();
        cyc(); instr(15, 1, 1, 5, 0, 0, 0, 0); rst = 1;
        @(negedge clk); chk("rst_pre_stall_D", stall_D, 1);
        cyc(); rst = 0;
        @(negedge clk);
        chk("rst_post_stall_D", stall_D, 0); chk("rst_post_stall_F", stall_F, 0);
        chk("rst_post_stall_X", stall_X, 0); chk("rst_post_stall_M", stall_M, 0);
        chk("rst_post_sel1", op1_byp_sel_D, 0); chk("rst_post_rf_wen", rf_wen_W, 0);
        cyc(); idle(); @(negedge clk); chk("rst_drop_wen_c2", rf_wen_W, 0);
        cyc(); @(negedge clk); chk("rst_drop_wen_c3", rf_wen_W, 0);

        // randomized traffic checked by the model every cycle
        for (int i = 0; i < 3000; i++) begin
            int c;
            cyc();
            rst        = ($urandom_range(0, 199) == 0);
            val_D      = ($urandom_range(0, 9) < 8);
            squash_D   = ($urandom_range(0, 9) == 0);
            rs1_en_D   = ($urandom_range(0, 9) < 8);
            rs2_en_D   = ($urandom_range(0, 9) < 6);
            rs1_D      = AW'($urandom_range(0, 3));
            rs2_D      = AW'($urandom_range(0, 3));
            rf_wen_D   = ($urandom_range(0, 9) < 8);
            rd_D       = AW'($urandom_range(0, 3));
            c          = $urandom_range(0, 9);
            is_lw_D    = (c < 2);
            is_mul_D   = (c >= 2 && c < 4);
            mem_wait_M = ($urandom_range(0, 6) == 0);
        end
        cyc();
        idle();
        rst = 0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
